// File: rtl/aclk_pkg.sv
// Shared types, limits and helpers for the alarm-clock time counter.
// BCD digit helpers and the 24 h to 12 h hour translation.
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic pm;
        bcd_t ms;
        bcd_t ls;
    } hr12_t;

    localparam int MAX_HR_24 = 23;
    localparam int MAX_MIN   = 59;
    localparam int MAX_SEC   = 59;

    function automatic logic bcd_valid(bcd_t digit, bcd_t max);
        return digit <= max;
    endfunction

    function automatic logic [6:0] bcd_bin(bcd_t ms, bcd_t ls);
        return 7'(ms) * 7'd10 + 7'(ls);
    endfunction

    // Hour 00 reads as 12; 13..23 fold down by 12; pm follows the raw hour.
    function automatic hr12_t to_12h(logic [7:0] h_bcd);
        logic [6:0] h;
        logic [6:0] d;
        hr12_t      r;
        h = bcd_bin(h_bcd[7:4], h_bcd[3:0]);
        if (h == 7'd0)
            d = 7'd12;
        else if (h > 7'd12)
            d = h - 7'd12;
        else
            d = h;
        r.pm = (h >= 7'd12);
        r.ms = (d >= 7'd10) ? 4'd1 : 4'd0;
        r.ls = (d >= 7'd10) ? 4'(d - 7'd10) : 4'(d);
        return r;
    endfunction

endpackage

// File: rtl/aclk_bcd_mod_counter.sv
// Two-digit BCD modulo counter with synchronous load and an at-max flag.
// wrap is high while the value equals MAX, i.e. the next inc rolls to 00.
module aclk_bcd_mod_counter
    import aclk_pkg::*;
#(
    parameter int MAX     = 59,
    parameter int RST_VAL = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  bcd_t load_ms,
    input  bcd_t load_ls,
    output bcd_t ms,
    output bcd_t ls,
    output logic wrap
);

    localparam bcd_t MAX_MS = 4'(MAX / 10);
    localparam bcd_t MAX_LS = 4'(MAX % 10);
    localparam bcd_t RST_MS = 4'(RST_VAL / 10);
    localparam bcd_t RST_LS = 4'(RST_VAL % 10);

    assign wrap = (ms == MAX_MS) && (ls == MAX_LS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ms <= RST_MS;
            ls <= RST_LS;
        end else if (load) begin
            ms <= load_ms;
            ls <= load_ls;
        end else if (inc) begin
            if (wrap) begin
                ms <= 4'd0;
                ls <= 4'd0;
            end else if (ls == 4'd9) begin
                ms <= ms + 4'd1;
                ls <= 4'd0;
            end else begin
                ls <= ls + 4'd1;
            end
        end
    end

endmodule

// File: rtl/aclk_time_counter.sv
// BCD time-of-day counter: optional seconds, checked loads, set-mode
// adjust, 12/24 h display and registered rollover pulses.
module aclk_time_counter
    import aclk_pkg::*;
#(
    parameter bit HAS_SECONDS = 1'b1,
    parameter int RESET_HR    = 0,
    parameter int RESET_MIN   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic load,
    input  bcd_t new_hr_ms,
    input  bcd_t new_hr_ls,
    input  bcd_t new_min_ms,
    input  bcd_t new_min_ls,
    input  bcd_t new_sec_ms,
    input  bcd_t new_sec_ls,
    input  logic inc_hr,
    input  logic inc_min,
    input  logic mode_12h,
    output bcd_t hr_ms,
    output bcd_t hr_ls,
    output bcd_t min_ms,
    output bcd_t min_ls,
    output bcd_t sec_ms,
    output bcd_t sec_ls,
    output logic pm,
    output logic load_err,
    output logic min_pulse,
    output logic hr_pulse,
    output logic day_pulse
);

    bcd_t  h_ms, h_ls, m_ms, m_ls, s_ms, s_ls;
    logic  h_wrap, m_wrap, s_wrap;
    logic  hr_ok, min_ok, sec_ok, valid;
    logic  load_ok, load_bad, adj, adj_hr, adj_min, adv;
    logic  m_carry, h_carry, d_carry;
    hr12_t h12;

    assign hr_ok  = bcd_valid(new_hr_ms, 4'd9)
                 && bcd_valid(new_hr_ls, 4'd9)
                 && (bcd_bin(new_hr_ms, new_hr_ls)
                     <= 7'(MAX_HR_24));
    assign min_ok = bcd_valid(new_min_ms, 4'd5)
                 && bcd_valid(new_min_ls, 4'd9);
    assign sec_ok = !HAS_SECONDS
                 || (bcd_valid(new_sec_ms, 4'd5)
                     && bcd_valid(new_sec_ls, 4'd9));
    assign valid  = hr_ok && min_ok && sec_ok;

    // A rejected load still owns the cycle: adjust and tick are dropped.
    assign load_ok  = load && valid;
    assign load_bad = load && !valid;
    assign adj      = !load && (inc_hr || inc_min);
    assign adj_hr   = adj && inc_hr;
    assign adj_min  = adj && inc_min;
    assign adv      = !load && !(inc_hr || inc_min) && tick;

    assign m_carry = adv && s_wrap;
    assign h_carry = m_carry && m_wrap;
    assign d_carry = h_carry && h_wrap;

    generate
        if (HAS_SECONDS) begin : g_sec
            aclk_bcd_mod_counter #(
                .MAX     (MAX_SEC),
                .RST_VAL (0)
            ) u_sec (
                .clk     (clk),
                .rst     (rst),
                .inc     (adv),
                .load    (load_ok || adj_min),
                .load_ms (load_ok ? new_sec_ms : 4'd0),
                .load_ls (load_ok ? new_sec_ls : 4'd0),
                .ms      (s_ms),
                .ls      (s_ls),
                .wrap    (s_wrap)
            );
        end else begin : g_nosec
            // Every tick is a whole minute, so it always carries.
            assign s_ms   = 4'd0;
            assign s_ls   = 4'd0;
            assign s_wrap = 1'b1;
        end
    endgenerate

    aclk_bcd_mod_counter #(
        .MAX     (MAX_MIN),
        .RST_VAL (RESET_MIN)
    ) u_min (
        .clk     (clk),
        .rst     (rst),
        .inc     (adj_min || m_carry),
        .load    (load_ok),
        .load_ms (new_min_ms),
        .load_ls (new_min_ls),
        .ms      (m_ms),
        .ls      (m_ls),
        .wrap    (m_wrap)
    );

    aclk_bcd_mod_counter #(
        .MAX     (MAX_HR_24),
        .RST_VAL (RESET_HR)
    ) u_hr (
        .clk     (clk),
        .rst     (rst),
        .inc     (adj_hr || h_carry),
        .load    (load_ok),
        .load_ms (new_hr_ms),
        .load_ls (new_hr_ls),
        .ms      (h_ms),
        .ls      (h_ls),
        .wrap    (h_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err  <= 1'b0;
            min_pulse <= 1'b0;
            hr_pulse  <= 1'b0;
            day_pulse <= 1'b0;
        end else begin
            load_err  <= load_bad;
            min_pulse <= m_carry;
            hr_pulse  <= h_carry;
            day_pulse <= d_carry;
        end
    end

    assign h12    = to_12h({h_ms, h_ls});
    assign hr_ms  = mode_12h ? h12.ms : h_ms;
    assign hr_ls  = mode_12h ? h12.ls : h_ls;
    assign pm     = h12.pm;
    assign min_ms = m_ms;
    assign min_ls = m_ls;
    assign sec_ms = s_ms;
    assign sec_ls = s_ls;

endmodule

// File: tb/tb_aclk_time_counter.sv
// Random and directed checks of both counter builds against a
// seconds-of-day reference model.
module tb_aclk_time_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, load = 1'b0;
    logic        inc_hr = 1'b0, inc_min = 1'b0, mode_12h = 1'b0;
    logic [23:0] nd = '0;

    logic [3:0]  s_d [6];
    logic [3:0]  m_d [6];
    logic        s_pm, s_err, s_mp, s_hp, s_dp;
    logic        m_pm, m_err, m_mp, m_hp, m_dp;

    int checks = 0;
    int errors = 0;

    int          t  [2];
    logic [3:0]  fl [2];

    always #5 clk = ~clk;

    aclk_time_counter #(
        .HAS_SECONDS (1'b1),
        .RESET_HR    (7),
        .RESET_MIN   (30)
    ) u_s (
        .clk (clk), .rst (rst), .tick (tick), .load (load),
        .new_hr_ms (nd[23:20]), .new_hr_ls (nd[19:16]),
        .new_min_ms (nd[15:12]), .new_min_ls (nd[11:8]),
        .new_sec_ms (nd[7:4]), .new_sec_ls (nd[3:0]),
        .inc_hr (inc_hr), .inc_min (inc_min), .mode_12h (mode_12h),
        .hr_ms (s_d[0]), .hr_ls (s_d[1]),
        .min_ms (s_d[2]), .min_ls (s_d[3]),
        .sec_ms (s_d[4]), .sec_ls (s_d[5]),
        .pm (s_pm), .load_err (s_err),
        .min_pulse (s_mp), .hr_pulse (s_hp), .day_pulse (s_dp)
    );

    aclk_time_counter #(
        .HAS_SECONDS (1'b0),
        .RESET_HR    (7),
        .RESET_MIN   (30)
    ) u_m (
        .clk (clk), .rst (rst), .tick (tick), .load (load),
        .new_hr_ms (nd[23:20]), .new_hr_ls (nd[19:16]),
        .new_min_ms (nd[15:12]), .new_min_ls (nd[11:8]),
        .new_sec_ms (nd[7:4]), .new_sec_ls (nd[3:0]),
        .inc_hr (inc_hr), .inc_min (inc_min), .mode_12h (mode_12h),
        .hr_ms (m_d[0]), .hr_ls (m_d[1]),
        .min_ms (m_d[2]), .min_ls (m_d[3]),
        .sec_ms (m_d[4]), .sec_ls (m_d[5]),
        .pm (m_pm), .load_err (m_err),
        .min_pulse (m_mp), .hr_pulse (m_hp), .day_pulse (m_dp)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // k=0: seconds build (day = 86400 s); k=1: minutes build (1440 min).
    function automatic int units_hr(int k);
        return (k == 0) ? 3600 : 60;
    endfunction

    function automatic int day_len(int k);
        return 24 * units_hr(k);
    endfunction

    function automatic void split(int k, int v, output int h, output int m, output int s);
        h = v / units_hr(k);
        m = (k == 0) ? (v / 60) % 60 : v % 60;
        s = (k == 0) ? v % 60 : 0;
    endfunction

    function automatic int join_t(int k, int h, int m, int s);
        return (k == 0) ? h * 3600 + m * 60 + s : h * 60 + m;
    endfunction

    function automatic logic [23:0] exp_disp(int k, int v, logic m12);
        int h, m, s, d;
        split(k, v, h, m, s);
        d = h;
        if (m12) d = (h == 0) ? 12 : (h > 12 ? h - 12 : h);
        return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit load_valid(int k, logic [23:0] d);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if (d[23 - 4 * i -: 4] > 4'd9) ok = 1'b0;
        if (d[15:12] > 4'd5) ok = 1'b0;
        if (int'(d[23:20]) * 10 + int'(d[19:16]) > 23) ok = 1'b0;
        if (k == 0 && (d[7:4] > 4'd5 || d[3:0] > 4'd9)) ok = 1'b0;
        return ok;
    endfunction

    function automatic void model_reset();
        t[0] = join_t(0, 7, 30, 0);
        t[1] = join_t(1, 7, 30, 0);
        fl[0] = '0;
        fl[1] = '0;
    endfunction

    // fl = {load_err, min_pulse, hr_pulse, day_pulse}
    function automatic void model_edge();
        int h, m, s;
        for (int k = 0; k < 2; k++) begin
            fl[k] = '0;
            if (load) begin
                if (load_valid(k, nd))
                    t[k] = join_t(k,
                        int'(nd[23:20]) * 10 + int'(nd[19:16]),
                        int'(nd[15:12]) * 10 + int'(nd[11:8]),
                        int'(nd[7:4]) * 10 + int'(nd[3:0]));
                else
                    fl[k][3] = 1'b1;
            end else if (inc_hr || inc_min) begin
                split(k, t[k], h, m, s);
                if (inc_hr) h = (h + 1) % 24;
                if (inc_min) begin
                    m = (m + 1) % 60;
                    s = 0;
                end
                t[k] = join_t(k, h, m, s);
            end else if (tick) begin
                t[k] = (t[k] + 1) % day_len(k);
                fl[k][2] = (k == 1) || (t[k] % 60 == 0);
                fl[k][1] = (t[k] % units_hr(k) == 0);
                fl[k][0] = (t[k] == 0);
            end
        end
    endfunction

    task automatic compare();
        logic [23:0] so, mo;
        logic        epm;
        so = {s_d[0], s_d[1], s_d[2], s_d[3], s_d[4], s_d[5]};
        mo = {m_d[0], m_d[1], m_d[2], m_d[3], m_d[4], m_d[5]};
        check("s.disp", 32'(so), 32'(exp_disp(0, t[0], mode_12h)));
        check("m.disp", 32'(mo), 32'(exp_disp(1, t[1], mode_12h)));
        epm = (t[0] >= 12 * 3600);
        check("s.flags", 32'({s_pm, s_err, s_mp, s_hp, s_dp}),
              32'({epm, fl[0]}));
        epm = (t[1] >= 12 * 60);
        check("m.flags", 32'({m_pm, m_err, m_mp, m_hp, m_dp}),
              32'({epm, fl[1]}));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        compare();
    endtask

    task automatic op(logic ld, logic [23:0] d, logic ih, logic im, logic tk);
        load = ld; nd = d; inc_hr = ih; inc_min = im; tick = tk;
        step();
        load = 1'b0; inc_hr = 1'b0; inc_min = 1'b0; tick = 1'b0;
    endtask

    function automatic logic [23:0] rand_digits();
        int h, m, s;
        logic [23:0] d;
        logic [3:0]  junk;
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        s = $urandom_range(0, 59);
        if ($urandom_range(0, 9) < 4) begin
            m = 59;
            s = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(55, 59);
            if ($urandom_range(0, 1) == 0) h = 23;
        end
        d = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
             4'(s / 10), 4'(s % 10)};
        if ($urandom_range(0, 4) == 0) begin
            junk = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: d[23:20] = junk;
                1: d[19:16] = junk;
                2: d[15:12] = junk;
                3: d[11:8]  = junk;
                4: d[7:4]   = junk;
                default: d[3:0] = junk;
            endcase
        end
        return d;
    endfunction

    initial begin
        model_reset();
        #12;
        compare();
        rst = 1'b0;
        @(negedge clk);
        compare();
        mode_12h = 1'b1;
        #1;
        compare();
        mode_12h = 1'b0;

        op(1, 24'h235959, 0, 0, 0);
        op(0, '0, 0, 0, 1);
        op(0, '0, 0, 0, 0);
        op(1, 24'h095959, 0, 0, 0);
        op(0, '0, 0, 0, 1);
        op(1, 24'h195959, 0, 0, 0);
        op(0, '0, 0, 0, 1);
        op(1, 24'h240000, 0, 0, 1);
        op(1, 24'h126000, 0, 0, 1);
        op(0, '0, 0, 0, 0);
        op(1, 24'h134520, 0, 0, 0);
        op(0, '0, 1, 1, 1);
        mode_12h = 1'b1;
        #1;
        compare();
        op(1, 24'h005000, 0, 0, 0);
        op(1, 24'h115800, 0, 0, 0);
        op(0, '0, 0, 0, 1);
        op(0, '0, 0, 0, 1);
        mode_12h = 1'b0;

        // Reset lands while a full-day carry is pending.
        op(1, 24'h235959, 0, 0, 0);
        tick = 1'b1;
        rst = 1'b1;
        model_reset();
        #1;
        compare();
        step();
        @(negedge clk);
        rst = 1'b0;
        tick = 1'b0;
        #1;
        compare();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mode_12h = ~mode_12h;
            op($urandom_range(0, 99) < 8, rand_digits(),
               $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
